// File: rtl/fifo_wr_arbiter.sv
// Round-robin write-port arbiter in front of a DEPTH-entry byte fifo.
// Tracks fifo occupancy from its own write strobe and the fifo read strobe.
module fifo_wr_arbiter #(
    parameter int NREQ   = 4,
    parameter int DEPTH  = 16,
    parameter int AF_LVL = 12
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NREQ-1:0]   req,
    input  logic [NREQ*8-1:0] req_data,
    input  logic              fifo_ren,
    output logic [NREQ-1:0]   gnt,
    output logic              fifo_wen,
    output logic [7:0]        fifo_wdata,
    output logic [4:0]        count,
    output logic              full,
    output logic              almost_full
);

    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

    logic [NREQ-1:0] gnt_q, gnt_d;
    logic            fifo_wen_q, fifo_wen_d;
    logic [7:0]      fifo_wdata_q, fifo_wdata_d;
    logic [4:0]      count_q, count_d;
    logic [PW-1:0]   rr_ptr_q, rr_ptr_d;

    logic [NREQ-1:0] elig;
    logic            found;
    logic [PW-1:0]   win;
    logic            space;
    logic            rd_hit;

    function automatic logic [PW-1:0] rr_index(input logic [PW-1:0] base, input int k);
        int s;
        s = int'(base) + k;
        if (s >= NREQ) s = s - NREQ;
        return PW'(s);
    endfunction

    // A requester granted this cycle is masked so its still-high req is not counted twice.
    always_comb begin
        elig  = req & ~gnt_q;
        found = 1'b0;
        win   = '0;
        for (int k = 0; k < NREQ; k++) begin
            if (!found && elig[rr_index(rr_ptr_q, k)]) begin
                found = 1'b1;
                win   = rr_index(rr_ptr_q, k);
            end
        end
    end

    // The write in flight this cycle still lands; reads are not credited.
    always_comb begin
        space = fifo_wen_q ? (count_q < 5'(DEPTH - 1)) : (count_q < 5'(DEPTH));
    end

    always_comb begin
        gnt_d        = '0;
        fifo_wen_d   = 1'b0;
        fifo_wdata_d = fifo_wdata_q;
        rr_ptr_d     = rr_ptr_q;
        if (found && space) begin
            gnt_d[win]   = 1'b1;
            fifo_wen_d   = 1'b1;
            fifo_wdata_d = req_data[int'(win)*8 +: 8];
            rr_ptr_d     = (win == PW'(NREQ - 1)) ? '0 : win + PW'(1);
        end
    end

    always_comb begin
        rd_hit  = fifo_ren && (count_q != 5'd0);
        count_d = count_q;
        if (fifo_wen_q && !rd_hit) begin
            count_d = count_q + 5'd1;
        end else if (!fifo_wen_q && rd_hit) begin
            count_d = count_q - 5'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            gnt_q        <= '0;
            fifo_wen_q   <= 1'b0;
            fifo_wdata_q <= 8'h00;
            count_q      <= 5'd0;
            rr_ptr_q     <= '0;
        end else begin
            gnt_q        <= gnt_d;
            fifo_wen_q   <= fifo_wen_d;
            fifo_wdata_q <= fifo_wdata_d;
            count_q      <= count_d;
            rr_ptr_q     <= rr_ptr_d;
        end
    end

    assign gnt         = gnt_q;
    assign fifo_wen    = fifo_wen_q;
    assign fifo_wdata  = fifo_wdata_q;
    assign count       = count_q;
    assign full        = (count_q == 5'(DEPTH));
    assign almost_full = (count_q >= 5'(AF_LVL));

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Bench for fifo_wr_arbiter: behavioural model feeding a write scoreboard,
// plus directed scenarios for reset, fill, full/read, occupancy and random traffic.
module tb_fifo_wr_arbiter;

    localparam int NREQ   = 4;
    localparam int DEPTH  = 16;
    localparam int AF_LVL = 12;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  req;
    logic [31:0] req_data;
    logic        fifo_ren;
    logic [3:0]  gnt;
    logic        fifo_wen;
    logic [7:0]  fifo_wdata;
    logic [4:0]  count;
    logic        full;
    logic        almost_full;

    logic [7:0]  rdata [NREQ];

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic [3:0] g;
        logic [7:0] d;
    } exp_t;
    exp_t sbq[$];

    int         m_count;
    int         m_ptr;
    logic [3:0] m_gnt;
    logic       m_wen;
    logic [7:0] m_wdata;
    logic [3:0] prev_req;
    logic       prev_rst;

    always #5 clk = ~clk;

    always_comb begin
        req_data = '0;
        for (int i = 0; i < NREQ; i++) req_data[i*8 +: 8] = rdata[i];
    end

    fifo_wr_arbiter #(.NREQ(NREQ), .DEPTH(DEPTH), .AF_LVL(AF_LVL)) dut (
        .clk         (clk),
        .rst         (rst),
        .req         (req),
        .req_data    (req_data),
        .fifo_ren    (fifo_ren),
        .gnt         (gnt),
        .fifo_wen    (fifo_wen),
        .fifo_wdata  (fifo_wdata),
        .count       (count),
        .full        (full),
        .almost_full (almost_full)
    );

    // One clock: predict from current inputs, clock, then compare DUT against model/scoreboard.
    task automatic tick();
        logic [3:0] n_gnt;
        logic       n_wen;
        logic [7:0] n_wdata;
        int         n_count;
        int         n_ptr;
        logic [3:0] elig;
        logic [7:0] rot;
        int         w;
        exp_t       e;

        if (!rst && !prev_rst) begin
            for (int i = 0; i < NREQ; i++) begin
                if (prev_req[i] && !req[i] && !m_gnt[i]) begin
                    errors++;
                    $display("FAIL req_protocol: requester %0d dropped req before grant", i);
                end
            end
        end

        if (rst) begin
            n_gnt = '0; n_wen = 1'b0; n_wdata = 8'h00; n_count = 0; n_ptr = 0;
            sbq.delete();
        end else begin
            n_count = m_count + (m_wen ? 1 : 0) - ((fifo_ren && m_count != 0) ? 1 : 0);
            n_gnt   = '0;
            n_wen   = 1'b0;
            n_wdata = m_wdata;
            n_ptr   = m_ptr;
            elig    = req & ~m_gnt;
            if (elig != 4'b0000 && (m_count + (m_wen ? 1 : 0)) < DEPTH) begin
                rot = {elig, elig} >> m_ptr;
                w = 0;
                for (int k = NREQ - 1; k >= 0; k--) if (rot[k]) w = k;
                w       = (m_ptr + w) % NREQ;
                n_gnt   = 4'b0001 << w;
                n_wen   = 1'b1;
                n_wdata = rdata[w];
                n_ptr   = (w + 1) % NREQ;
                e.g = n_gnt;
                e.d = n_wdata;
                sbq.push_back(e);
            end
        end
        prev_req = req;
        prev_rst = rst;

        @(posedge clk);
        m_gnt = n_gnt; m_wen = n_wen; m_wdata = n_wdata; m_count = n_count; m_ptr = n_ptr;
        @(negedge clk);

        checks++;
        if (fifo_wen !== m_wen) begin
            errors++;
            $display("FAIL sb_wen: got %b expected %b", fifo_wen, m_wen);
        end
        if (fifo_wen === 1'b1) begin
            checks++;
            if (sbq.size() == 0) begin
                errors++;
                $display("FAIL sb_write: unexpected write gnt=%b data=%h", gnt, fifo_wdata);
            end else begin
                e = sbq.pop_front();
                if (gnt !== e.g || fifo_wdata !== e.d) begin
                    errors++;
                    $display("FAIL sb_write: got gnt=%b data=%h expected gnt=%b data=%h",
                             gnt, fifo_wdata, e.g, e.d);
                end
            end
        end else begin
            sbq.delete();
            checks++;
            if (gnt !== 4'b0000) begin
                errors++;
                $display("FAIL sb_idle_gnt: got %b expected 0000", gnt);
            end
        end
        checks++;
        if (fifo_wdata !== m_wdata) begin
            errors++;
            $display("FAIL sb_wdata_hold: got %h expected %h", fifo_wdata, m_wdata);
        end
        checks++;
        if (count !== 5'(m_count)) begin
            errors++;
            $display("FAIL sb_count: got %0d expected %0d", count, m_count);
        end
        checks++;
        if (full !== (m_count == DEPTH) || almost_full !== (m_count >= AF_LVL)) begin
            errors++;
            $display("FAIL sb_flags: got full=%b af=%b expected full=%b af=%b",
                     full, almost_full, (m_count == DEPTH), (m_count >= AF_LVL));
        end
        checks++;
        if (!$onehot0(gnt) || fifo_wen !== (|gnt) || count > 5'(DEPTH) || (fifo_wen & full) === 1'b1) begin
            errors++;
            $display("FAIL invariants: gnt=%b wen=%b count=%0d full=%b", gnt, fifo_wen, count, full);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1; req = 4'b0000; fifo_ren = 1'b0;
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        req = 4'b1111;
        for (int i = 0; i < NREQ; i++) rdata[i] = 8'(8'h10 + i);
        repeat (2) begin
            tick();
            checks++;
            if (gnt !== 4'b0000 || fifo_wen !== 1'b0 || count !== 5'd0) begin
                errors++;
                $display("FAIL reset_state: got gnt=%b wen=%b count=%0d expected 0000/0/0", gnt, fifo_wen, count);
            end
        end
    endtask

    task automatic test_single_grant();
        rst = 1'b0;
        req = 4'b0100;
        rdata[2] = 8'h80;
        tick();
        checks++;
        if (gnt !== 4'b0100 || fifo_wdata !== 8'h80) begin
            errors++;
            $display("FAIL single_gnt: got gnt=%b data=%h expected 0100/80", gnt, fifo_wdata);
        end
        req = 4'b0000;
        tick();
        checks++;
        if (count !== 5'd1 || gnt !== 4'b0000) begin
            errors++;
            $display("FAIL single_count: got count=%0d gnt=%b expected 1/0000", count, gnt);
        end
    endtask

    task automatic test_round_robin_fill();
        int         ngr;
        bit         seen_af;
        logic [3:0] expg;
        do_reset();
        for (int i = 0; i < NREQ; i++) rdata[i] = 8'(8'h10 + i);
        req = 4'b1111;
        ngr = 0;
        seen_af = 1'b0;
        repeat (24) begin
            tick();
            if (fifo_wen === 1'b1) begin
                expg = 4'b0001 << (ngr % NREQ);
                checks++;
                if (gnt !== expg) begin
                    errors++;
                    $display("FAIL rr_order: grant %0d got %b expected %b", ngr, gnt, expg);
                end
                ngr++;
            end
            if (!seen_af && almost_full === 1'b1) begin
                seen_af = 1'b1;
                checks++;
                if (count !== 5'(AF_LVL)) begin
                    errors++;
                    $display("FAIL af_level: almost_full rose at count %0d expected %0d", count, AF_LVL);
                end
            end
        end
        checks++;
        if (ngr != DEPTH || count !== 5'(DEPTH) || full !== 1'b1 || !seen_af) begin
            errors++;
            $display("FAIL fill_stop: got grants=%0d count=%0d full=%b af_seen=%0d expected 16/16/1/1",
                     ngr, count, full, seen_af);
        end
    endtask

    task automatic test_full_read();
        int k;
        do_reset();
        rdata[1] = 8'h21;
        req = 4'b0010;
        k = 0;
        while (m_count != DEPTH && k < 80) begin
            tick();
            k++;
        end
        checks++;
        if (count !== 5'(DEPTH)) begin
            errors++;
            $display("FAIL full_reach: got count=%0d expected 16 within budget", count);
        end
        fifo_ren = 1'b1;
        tick();
        fifo_ren = 1'b0;
        checks++;
        if (count !== 5'd15 || gnt !== 4'b0000) begin
            errors++;
            $display("FAIL full_read: got count=%0d gnt=%b expected 15/0000", count, gnt);
        end
        tick();
        checks++;
        if (gnt !== 4'b0010 || count !== 5'd15) begin
            errors++;
            $display("FAIL full_regrant: got gnt=%b count=%0d expected 0010/15", gnt, count);
        end
        req = 4'b0000;
        repeat (3) begin
            tick();
            checks++;
            if (gnt !== 4'b0000 || count !== 5'(DEPTH) || full !== 1'b1) begin
                errors++;
                $display("FAIL full_after: got gnt=%b count=%0d full=%b expected 0000/16/1", gnt, count, full);
            end
        end
    endtask

    task automatic test_occupancy();
        int k;
        do_reset();
        fifo_ren = 1'b1;
        repeat (3) begin
            tick();
            checks++;
            if (count !== 5'd0) begin
                errors++;
                $display("FAIL empty_read: got count=%0d expected 0", count);
            end
        end
        fifo_ren = 1'b0;
        rdata[0] = 8'h55;
        req = 4'b0001;
        k = 0;
        while (!(m_count == 5 && m_wen) && k < 40) begin
            tick();
            k++;
        end
        checks++;
        if (fifo_wen !== 1'b1 || count !== 5'd5) begin
            errors++;
            $display("FAIL wr_rd_setup: got wen=%b count=%0d expected 1/5", fifo_wen, count);
        end
        req = 4'b0000;
        fifo_ren = 1'b1;
        tick();
        fifo_ren = 1'b0;
        checks++;
        if (count !== 5'd5) begin
            errors++;
            $display("FAIL wr_rd_same: got count=%0d expected 5", count);
        end
        tick();
    endtask

    task automatic test_reset_in_flight();
        int k;
        do_reset();
        rdata[0] = 8'h0A;
        req = 4'b0001;
        k = 0;
        while (!(m_count == 7 && m_wen) && k < 40) begin
            tick();
            k++;
        end
        checks++;
        if (fifo_wen !== 1'b1 || count !== 5'd7) begin
            errors++;
            $display("FAIL inflight_setup: got wen=%b count=%0d expected 1/7", fifo_wen, count);
        end
        rst = 1'b1;
        tick();
        checks++;
        if (count !== 5'd0 || gnt !== 4'b0000 || fifo_wen !== 1'b0) begin
            errors++;
            $display("FAIL inflight_reset: got count=%0d gnt=%b wen=%b expected 0/0000/0", count, gnt, fifo_wen);
        end
        rst = 1'b0;
        rdata[3] = 8'h33;
        req = 4'b1001;
        tick();
        checks++;
        if (gnt !== 4'b0001) begin
            errors++;
            $display("FAIL ptr_reset: got gnt=%b expected 0001", gnt);
        end
        req = 4'b1000;
        tick();
        checks++;
        if (gnt !== 4'b1000 || fifo_wdata !== 8'h33) begin
            errors++;
            $display("FAIL ptr_next: got gnt=%b data=%h expected 1000/33", gnt, fifo_wdata);
        end
        req = 4'b0000;
        tick();
    endtask

    task automatic test_random();
        do_reset();
        repeat (400) begin
            for (int i = 0; i < NREQ; i++) begin
                if (req[i]) begin
                    if (m_gnt[i]) begin
                        if ($urandom_range(1, 0) == 1) req[i] = 1'b0;
                        else rdata[i] = 8'($urandom);
                    end
                end else if ($urandom_range(9, 0) < 3) begin
                    req[i]   = 1'b1;
                    rdata[i] = 8'($urandom);
                end
            end
            fifo_ren = ($urandom_range(9, 0) < 4);
            tick();
        end
        fifo_ren = 1'b0;
    endtask

    initial begin
        rst = 1'b1; req = 4'b0000; fifo_ren = 1'b0;
        for (int i = 0; i < NREQ; i++) rdata[i] = 8'h00;
        m_count = 0; m_ptr = 0; m_gnt = '0; m_wen = 1'b0; m_wdata = 8'h00;
        prev_req = '0; prev_rst = 1'b1;

        test_reset();
        test_single_grant();
        test_round_robin_fill();
        test_full_read();
        test_occupancy();
        test_reset_in_flight();
        test_random();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
